// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, frame width and divisor helper
// for the 8N1 UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Clocks per baud tick, rounded to the nearest integer.
    function automatic int calc_div(
        input int clk_freq,
        input int baud,
        input int oversample
    );
        int den;
        den = baud * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: host byte request side plus the serial line
// and debug observation signals of the transmitter.
interface uart_tx_core_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_in;
    logic                 tx_start;
    logic                 tx;
    logic                 tx_done;
    logic                 baud_tick;
    uart_state_e          state;

    modport master (
        output tx_in,
        output tx_start,
        input  tx,
        input  tx_done,
        input  baud_tick,
        input  state
    );

    modport slave (
        input  tx_in,
        input  tx_start,
        output tx,
        output tx_done,
        output baud_tick,
        output state
    );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider, one-clock tick every
// DIV clocks, independent of the framing FSM.
module uart_baud_gen #(
    parameter int DIV = 104
) (
    input  logic clock,
    input  logic reset,
    output logic baud_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign baud_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serialiser. Start bit, 8 data bits LSB
// first, stop bit; every bit is OVERSAMPLE baud ticks long.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input logic           clock,
    input logic           reset,
    uart_tx_core_if.slave bus
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic                 tick;
    logic                 bit_end;
    uart_state_e          state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud (
        .clock    (clock),
        .reset    (reset),
        .baud_tick(tick)
    );

    assign bit_end = tick && (cnt_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    sh_d    = bus.tx_in;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_d  = sh_q >> 1;
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tick) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
        endcase

        // Line level follows the next state so tx is a clean flop.
        unique case (1'b1)
            state_d == START: tx_d = 1'b0;
            state_d == DATA:  tx_d = sh_d[0];
            default:          tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.tx_done   = done_q;
    assign bus.baud_tick = tick;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: random bytes through the transmitter; a line
// monitor rebuilds each frame and checks it against a scoreboard.
module tb_uart_tx_core;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_950_000;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    // 1_950_000 / 153_600 = 12.7 -> nearest is 13
    localparam int EXP_DIV  = 13;
    localparam int BIT_CLKS = OS * EXP_DIV;
    localparam int BUDGET   = 11 * BIT_CLKS + 50;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_tx_core_if bus ();

    uart_tx_core #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    int frames_exp  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Line monitor: frame position is measured in baud ticks
    // from the falling edge of the start bit.
    int         since_rel = 0;
    int         last_tick = -1;
    int         ticks     = 0;
    bit         in_frame  = 0;
    bit         done_due  = 0;
    logic       prev_tx   = 1'b1;
    logic [7:0] got       = '0;

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_tx", 32'(bus.tx), 1);
            check("rst_done", 32'(bus.tx_done), 0);
            check("rst_state", 32'(bus.state), 0);
            check("rst_tick", 32'(bus.baud_tick), 0);
            since_rel = 0;
            last_tick = -1;
            in_frame  = 0;
            done_due  = 0;
            prev_tx   = 1'b1;
        end else begin
            since_rel++;
            if (bus.baud_tick) begin
                if (last_tick < 0)
                    check("tick_first", since_rel, EXP_DIV);
                else
                    check("tick_gap", since_rel - last_tick, EXP_DIV);
                last_tick = since_rel;
            end
            if (done_due) begin
                done_due = 0;
                check("done_pulse", 32'(bus.tx_done), 1);
                if (exp_q.size() == 0)
                    check("sb_underflow", 1, 0);
                else
                    check("byte", 32'(got), 32'(exp_q.pop_front()));
                done_seen++;
            end else if (bus.tx_done) begin
                check("spurious_done", 1, 0);
            end
            if (!in_frame && prev_tx && !bus.tx) begin
                in_frame = 1;
                ticks    = 0;
                got      = '0;
            end
            if (in_frame && bus.baud_tick) begin
                ticks++;
                if (ticks == 8) begin
                    check("start_bit", 32'(bus.tx), 0);
                    check("st_start", 32'(bus.state), 1);
                end else if (ticks >= 24 && ticks <= 136 &&
                             (ticks - 24) % 16 == 0) begin
                    got[(ticks - 24) / 16] = bus.tx;
                    check("st_data", 32'(bus.state), 2);
                end else if (ticks == 152) begin
                    check("stop_bit", 32'(bus.tx), 1);
                    check("st_stop", 32'(bus.state), 3);
                end else if (ticks == 160) begin
                    in_frame = 0;
                    done_due = 1;
                end
            end
            prev_tx = bus.tx;
        end
    end

    task automatic wait_done();
        int n0;
        int k;
        n0 = done_seen;
        k  = 0;
        while (done_seen == n0 && k < BUDGET) begin
            @(posedge clock);
            k++;
        end
        if (done_seen == n0) check("done_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] b,
                        input bit corrupt,
                        input logic [7:0] alt);
        @(posedge clock);
        #1;
        bus.tx_in    = b;
        bus.tx_start = 1'b1;
        exp_q.push_back(b);
        frames_exp++;
        @(posedge clock);
        #1;
        bus.tx_start = 1'b0;
        check("go_state", 32'(bus.state), 1);
        check("go_tx", 32'(bus.tx), 0);
        if (corrupt) begin
            repeat (3 * BIT_CLKS) @(posedge clock);
            #1;
            bus.tx_in = alt;
        end
        wait_done();
    endtask

    task automatic held(input logic [7:0] b, input int n);
        @(posedge clock);
        #1;
        bus.tx_in    = b;
        bus.tx_start = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(b);
            frames_exp++;
        end
        for (int i = 0; i < n; i++) begin
            wait_done();
            #1;
            if (i < n - 1) begin
                check("b2b_state", 32'(bus.state), 1);
                check("b2b_tx", 32'(bus.tx), 0);
                if (i == n - 2) bus.tx_start = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        bus.tx_in    = '0;
        bus.tx_start = 1'b0;
        #1 reset = 1'b0;
        #100;
        @(posedge clock);
        #1 reset = 1'b1;

        repeat (4 * EXP_DIV + 3) @(posedge clock);
        #1;
        check("idle_tx", 32'(bus.tx), 1);
        check("idle_state", 32'(bus.state), 0);

        send(8'h75, 1'b1, 8'hFF);

        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom_range(0, 255));
            send(r, 1'($urandom_range(0, 1)), ~r);
        end

        held(8'h75, 3);

        r = 8'($urandom_range(0, 255));
        @(posedge clock);
        #1;
        bus.tx_in    = r;
        bus.tx_start = 1'b1;
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        bus.tx_start = 1'b0;
        repeat (4 * BIT_CLKS + $urandom_range(0, BIT_CLKS))
            @(posedge clock);
        #1;
        check("pre_abort_state", 32'(bus.state), 2);
        reset = 1'b0;
        #1;
        check("abort_tx", 32'(bus.tx), 1);
        check("abort_state", 32'(bus.state), 0);
        check("abort_done", 32'(bus.tx_done), 0);
        void'(exp_q.pop_back());
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;

        for (int i = 0; i < 2; i++) begin
            r = 8'($urandom_range(0, 255));
            send(r, 1'b0, 8'h00);
        end

        repeat (3) @(posedge clock);
        check("sb_left", exp_q.size(), 0);
        check("frames", done_seen, frames_exp);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
